decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Sits directly downstream of the fetch stage and upstream of execute.
- Accepts one fetched packet (exec mask, PC, 32-bit instruction) per handshake.
- Cracks the packet into opcode, register fields and a sign-extended immediate.
- Holds the packet in a register scoreboard until its operands have no pending writer, then issues it to execute.

Parameters:
- NUM_REGS, 16, architectural registers; the register field is clog2(NUM_REGS) = 4 bits.
- ADDR_W, 32, memory_address_t width.
- MASK_W, 64, execution_mask_t width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  fetch has a packet.
- in_exec_mask  in  MASK_W  thread execution mask.
- in_pc  in  ADDR_W  instruction PC.
- in_insn  in  32  raw instruction_t.
- in_busy  out  1  decode cannot accept (fetch's is_busy).
- out_valid  out  1  decoded packet is issuable.
- out_busy  in  1  execute cannot accept.
- out_exec_mask  out  MASK_W  forwarded mask.
- out_pc  out  ADDR_W  forwarded PC.
- out_opcode  out  8  insn[7:0].
- out_rd, out_rs1, out_rs2  out  4 each  insn[11:8], [15:12], [19:16].
- out_imm  out  32  sign-extended immediate.
- out_writes_rd, out_reads_rs1, out_reads_rs2  out  1 each  operand usage flags.
- out_is_cf  out  1  control-flow instruction.
- out_illegal  out  1  unknown opcode.
- wb_valid  in  1  writeback completes this cycle.
- wb_reg  in  4  register written back.

Behaviour:
- State: a one-entry hold register (hold_valid plus decoded fields) and scoreboard[NUM_REGS-1:0] of pending-writer bits.
- Reset: hold_valid=0, scoreboard=0, so out_valid=0 and in_busy=0. All out_* data fields reset to 0.
- Reset mid-operation: a held packet is discarded, not issued.
- Accept: when in_valid && !in_busy, decode in_insn and load the hold register at the next clk edge. Latency from accept to out_valid is 1 cycle at minimum.
- Decode rules (opcode values are fixed in the package):
  - NOP 0x00, HALT 0x01: no operands.
  - MOVE_IMM 0x02: writes rd; imm = sext(insn[31:16]).
  - ADD 0x03, SUB 0x04: writes rd; reads rs1 and rs2.
  - CMP 0x05: reads rs1 and rs2.
  - LOAD 0x06: writes rd; reads rs1; imm = sext(insn[31:20]).
  - STORE 0x07: reads rs1 and rs2; imm = sext(insn[31:20]).
  - JMP_ALWAYS 0x10 through JMP_LOWER_EQUAL 0x16: imm = sext(insn[31:16]).
  - LOAD_RESTORE_PC 0x17: reads rs1.
  - any other value: illegal, all usage flags 0, imm 0.
  - Opcodes without an immediate: imm = 0.
- out_is_cf = 1 for HALT, all JMP_*, and LOAD_RESTORE_PC (same set fetch uses to stop fetching).
- Hazard: asserted when the held packet has (reads_rs1 && sb[rs1]) or (reads_rs2 && sb[rs2]) or (writes_rd && sb[rd]). Only the registered scoreboard is checked; there is no same-cycle wb bypass.
- Issue: out_valid = hold_valid && !hazard. A transfer (fire) happens when out_valid && !out_busy.
  - On fire: hold_valid clears, and if writes_rd, scoreboard[rd] sets.
- in_busy = hold_valid && !fire, combinational from out_busy. This permits back-to-back accept/issue at one packet per cycle.
- Writeback: wb_valid clears scoreboard[wb_reg] at the clock edge. If a fire sets the same register in the same cycle, the set wins.
- out_* fields stay stable while out_valid && out_busy. Illegal instructions are issued normally with out_illegal=1.
- in_valid while in_busy is ignored; fetch must hold its packet.

Decomposition:
- Shared package decode_pkg (or the existing CPU package):
  - Opcode enum with the values above.
  - REG_IDX_W.
  - The DecodeToExecute packet struct.
  - A function is_control_flow(Opcode) shared with fetch.
- Sub-module decode_scoreboard: the NUM_REGS bit vector with set/clear ports and a combinational hazard output.
- The field cracker is a pure function kept in the package.

Test Plan:
- After reset, in_valid=1, insn=0x00000203 (ADD rd=2, rs1=0, rs2=0) with out_busy=0 → next cycle out_valid=1, out_opcode=0x03, out_rd=2, out_writes_rd=1; scoreboard[2]=1 after fire.
- ADD rd=2 followed by ADD reading rs1=2 (insn 0x00002303) → the second packet stalls with out_valid=0 and in_busy=1 until wb_valid=1, wb_reg=2; out_valid rises the cycle after the wb edge.
- MOVE_IMM insn 0xFFFE0102 → out_imm=0xFFFFFFFE, out_rd=1. LOAD insn 0x80016106 → out_imm=0xFFFFF800.
- JMP_EQUAL insn 0x00400011 → out_is_cf=1, imm=0x40, no usage flags. Opcode 0x3F → out_illegal=1, writes_rd=0.
- out_busy=1 held for 3 cycles with a valid entry → out_* stable, in_busy=1, no second accept. Releasing out_busy with a new in_valid in the same cycle → fire and accept together, next packet appears the next cycle.
- Reset asserted while the hold register is full and out_busy=1 → next cycle out_valid=0, in_busy=0, scoreboard all zero.

Source files
------------

// File: rtl/decode_stage_pkg.sv
//============================================================================
// Module : decode_stage_pkg
// Shared decode types, opcode map and the field cracker used by decode/fetch.
// Rev    : 1.0
//============================================================================
`default_nettype none

package decode_stage_pkg;

   localparam int NUM_REGS  = 16;
   localparam int REG_IDX_W = $clog2(NUM_REGS);
   localparam int ADDR_W    = 32;
   localparam int MASK_W    = 64;

   typedef logic [ADDR_W-1:0]    memory_address_t;
   typedef logic [MASK_W-1:0]    execution_mask_t;
   typedef logic [31:0]          instruction_t;
   typedef logic [REG_IDX_W-1:0] reg_idx_t;

   typedef enum logic [7:0] {
      OP_NOP               = 8'h00,
      OP_HALT              = 8'h01,
      OP_MOVE_IMM          = 8'h02,
      OP_ADD               = 8'h03,
      OP_SUB               = 8'h04,
      OP_CMP               = 8'h05,
      OP_LOAD              = 8'h06,
      OP_STORE             = 8'h07,
      OP_JMP_ALWAYS        = 8'h10,
      OP_JMP_EQUAL         = 8'h11,
      OP_JMP_NOT_EQUAL     = 8'h12,
      OP_JMP_GREATER       = 8'h13,
      OP_JMP_GREATER_EQUAL = 8'h14,
      OP_JMP_LOWER         = 8'h15,
      OP_JMP_LOWER_EQUAL   = 8'h16,
      OP_LOAD_RESTORE_PC   = 8'h17
   } opcode_e;

   typedef struct packed {
      logic [7:0]  opcode;
      reg_idx_t    rd;
      reg_idx_t    rs1;
      reg_idx_t    rs2;
      logic [31:0] imm;
      logic        writes_rd;
      logic        reads_rs1;
      logic        reads_rs2;
      logic        is_cf;
      logic        illegal;
   } decoded_t;

   typedef struct packed {
      execution_mask_t exec_mask;
      memory_address_t pc;
      decoded_t        dec;
   } decode_to_execute_t;

   // Raw opcode byte so that unknown encodings can be classified too.
   function automatic logic is_control_flow(input logic [7:0] op);
      case (op)
         OP_HALT,
         OP_JMP_ALWAYS, OP_JMP_EQUAL, OP_JMP_NOT_EQUAL, OP_JMP_GREATER,
         OP_JMP_GREATER_EQUAL, OP_JMP_LOWER, OP_JMP_LOWER_EQUAL,
         OP_LOAD_RESTORE_PC: return 1'b1;
         default:            return 1'b0;
      endcase
   endfunction

   function automatic decoded_t crack_insn(input instruction_t insn);
      decoded_t d;
      d        = '0;
      d.opcode = insn[7:0];
      d.rd     = insn[11:8];
      d.rs1    = insn[15:12];
      d.rs2    = insn[19:16];
      case (insn[7:0])
         OP_NOP, OP_HALT: ;
         OP_MOVE_IMM: begin
            d.writes_rd = 1'b1;
            d.imm       = {{16{insn[31]}}, insn[31:16]};
         end
         OP_ADD, OP_SUB: begin
            d.writes_rd = 1'b1;
            d.reads_rs1 = 1'b1;
            d.reads_rs2 = 1'b1;
         end
         OP_CMP: begin
            d.reads_rs1 = 1'b1;
            d.reads_rs2 = 1'b1;
         end
         OP_LOAD: begin
            d.writes_rd = 1'b1;
            d.reads_rs1 = 1'b1;
            d.imm       = {{20{insn[31]}}, insn[31:20]};
         end
         OP_STORE: begin
            d.reads_rs1 = 1'b1;
            d.reads_rs2 = 1'b1;
            d.imm       = {{20{insn[31]}}, insn[31:20]};
         end
         OP_JMP_ALWAYS, OP_JMP_EQUAL, OP_JMP_NOT_EQUAL, OP_JMP_GREATER,
         OP_JMP_GREATER_EQUAL, OP_JMP_LOWER, OP_JMP_LOWER_EQUAL: begin
            d.imm = {{16{insn[31]}}, insn[31:16]};
         end
         OP_LOAD_RESTORE_PC: begin
            d.reads_rs1 = 1'b1;
         end
         default: begin
            d.illegal = 1'b1;
         end
      endcase
      d.is_cf = is_control_flow(insn[7:0]);
      return d;
   endfunction

endpackage

`default_nettype wire

// File: rtl/decode_stage_if.sv
//============================================================================
// Module : decode_stage_if
// Fetch-side, execute-side and writeback signals of the decode stage.
// Rev    : 1.0
//============================================================================
`default_nettype none

interface decode_stage_if;
   import decode_stage_pkg::*;

   logic            in_valid;
   execution_mask_t in_exec_mask;
   memory_address_t in_pc;
   instruction_t    in_insn;
   logic            in_busy;

   logic            out_valid;
   logic            out_busy;
   execution_mask_t out_exec_mask;
   memory_address_t out_pc;
   logic [7:0]      out_opcode;
   reg_idx_t        out_rd;
   reg_idx_t        out_rs1;
   reg_idx_t        out_rs2;
   logic [31:0]     out_imm;
   logic            out_writes_rd;
   logic            out_reads_rs1;
   logic            out_reads_rs2;
   logic            out_is_cf;
   logic            out_illegal;

   logic            wb_valid;
   reg_idx_t        wb_reg;

   modport master (
      output in_valid, in_exec_mask, in_pc, in_insn, out_busy, wb_valid, wb_reg,
      input  in_busy, out_valid, out_exec_mask, out_pc, out_opcode, out_rd,
             out_rs1, out_rs2, out_imm, out_writes_rd, out_reads_rs1,
             out_reads_rs2, out_is_cf, out_illegal
   );

   modport slave (
      input  in_valid, in_exec_mask, in_pc, in_insn, out_busy, wb_valid, wb_reg,
      output in_busy, out_valid, out_exec_mask, out_pc, out_opcode, out_rd,
             out_rs1, out_rs2, out_imm, out_writes_rd, out_reads_rs1,
             out_reads_rs2, out_is_cf, out_illegal
   );

endinterface

`default_nettype wire

// File: rtl/decode_stage_scoreboard.sv
//============================================================================
// Module : decode_stage_scoreboard
// Pending-writer bit per register; flags a hazard for the held packet.
// Rev    : 1.0
//============================================================================
`default_nettype none

module decode_stage_scoreboard #(
   parameter int NUM_REGS = 16
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        set_i,
   input  logic [$clog2(NUM_REGS)-1:0] set_reg_i,
   input  logic                        clr_i,
   input  logic [$clog2(NUM_REGS)-1:0] clr_reg_i,
   input  logic [$clog2(NUM_REGS)-1:0] rd_i,
   input  logic [$clog2(NUM_REGS)-1:0] rs1_i,
   input  logic [$clog2(NUM_REGS)-1:0] rs2_i,
   input  logic                        writes_rd_i,
   input  logic                        reads_rs1_i,
   input  logic                        reads_rs2_i,
   output logic                        hazard_o
);

   logic [NUM_REGS-1:0] sb_q;
   logic [NUM_REGS-1:0] sb_d;

   // Set is applied after clear so a new writer outranks a same-cycle writeback.
   always_comb begin
      sb_d = sb_q;
      if (clr_i) sb_d[clr_reg_i] = 1'b0;
      if (set_i) sb_d[set_reg_i] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) sb_q <= '0;
      else       sb_q <= sb_d;
   end

   assign hazard_o = (reads_rs1_i && sb_q[rs1_i]) ||
                     (reads_rs2_i && sb_q[rs2_i]) ||
                     (writes_rd_i && sb_q[rd_i]);

endmodule

`default_nettype wire

// File: rtl/decode_stage.sv
//============================================================================
// Module : decode_stage
// Cracks fetched packets and holds each one until its operands are free.
// Rev    : 1.0
//============================================================================
`default_nettype none

module decode_stage
   import decode_stage_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   decode_stage_if.slave bus
);

   decode_to_execute_t hold_q;
   decode_to_execute_t hold_d;
   logic               hold_valid_q;
   logic               hold_valid_d;
   logic               hazard;
   logic               issue;
   logic               fire;
   logic               accept;

   assign issue  = hold_valid_q && !hazard;
   assign fire   = issue && !bus.out_busy;
   assign accept = bus.in_valid && !(hold_valid_q && !fire);

   always_comb begin
      hold_d       = hold_q;
      hold_valid_d = hold_valid_q;
      if (fire) hold_valid_d = 1'b0;
      if (accept) begin
         hold_valid_d     = 1'b1;
         hold_d.exec_mask = bus.in_exec_mask;
         hold_d.pc        = bus.in_pc;
         hold_d.dec       = crack_insn(bus.in_insn);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hold_valid_q <= 1'b0;
         hold_q       <= '0;
      end else begin
         hold_valid_q <= hold_valid_d;
         hold_q       <= hold_d;
      end
   end

   decode_stage_scoreboard #(
      .NUM_REGS (NUM_REGS)
   ) u_scoreboard (
      .clk         (clk),
      .reset       (reset),
      .set_i       (fire && hold_q.dec.writes_rd),
      .set_reg_i   (hold_q.dec.rd),
      .clr_i       (bus.wb_valid),
      .clr_reg_i   (bus.wb_reg),
      .rd_i        (hold_q.dec.rd),
      .rs1_i       (hold_q.dec.rs1),
      .rs2_i       (hold_q.dec.rs2),
      .writes_rd_i (hold_q.dec.writes_rd),
      .reads_rs1_i (hold_q.dec.reads_rs1),
      .reads_rs2_i (hold_q.dec.reads_rs2),
      .hazard_o    (hazard)
   );

   assign bus.in_busy       = hold_valid_q && !fire;
   assign bus.out_valid     = issue;
   assign bus.out_exec_mask = hold_q.exec_mask;
   assign bus.out_pc        = hold_q.pc;
   assign bus.out_opcode    = hold_q.dec.opcode;
   assign bus.out_rd        = hold_q.dec.rd;
   assign bus.out_rs1       = hold_q.dec.rs1;
   assign bus.out_rs2       = hold_q.dec.rs2;
   assign bus.out_imm       = hold_q.dec.imm;
   assign bus.out_writes_rd = hold_q.dec.writes_rd;
   assign bus.out_reads_rs1 = hold_q.dec.reads_rs1;
   assign bus.out_reads_rs2 = hold_q.dec.reads_rs2;
   assign bus.out_is_cf     = hold_q.dec.is_cf;
   assign bus.out_illegal   = hold_q.dec.illegal;

endmodule

`default_nettype wire

// File: tb/tb_decode_stage.sv
//============================================================================
// Module : tb_decode_stage
// Self-checking bench for decode_stage: decode table plus stall/reset cases.
// Rev    : 1.0
//============================================================================
`default_nettype none

module tb_decode_stage;

   typedef struct packed {
      logic [63:0] mask;
      logic [31:0] pc;
      logic [7:0]  opcode;
      logic [3:0]  rd;
      logic [3:0]  rs1;
      logic [3:0]  rs2;
      logic [31:0] imm;
      logic        wr;
      logic        r1;
      logic        r2;
      logic        cf;
      logic        ill;
   } exp_t;

   typedef struct {
      logic [31:0] insn;
      exp_t        exp;
   } vec_t;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;
   exp_t cur_exp;
   exp_t exp_q[$];
   vec_t tbl[14];

   decode_stage_if dif ();

   decode_stage dut (
      .clk   (clk),
      .reset (reset),
      .bus   (dif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t mk(input logic [7:0] op, input logic [3:0] rd,
                               input logic [3:0] rs1, input logic [3:0] rs2,
                               input logic [31:0] imm, input logic [4:0] fl);
      exp_t e;
      e        = '0;
      e.opcode = op;
      e.rd     = rd;
      e.rs1    = rs1;
      e.rs2    = rs2;
      e.imm    = imm;
      {e.wr, e.r1, e.r2, e.cf, e.ill} = fl;
      return e;
   endfunction

   function automatic exp_t randctx(input exp_t e);
      exp_t r;
      r      = e;
      r.mask = {$urandom, $urandom};
      r.pc   = $urandom;
      return r;
   endfunction

   function automatic exp_t get_act();
      exp_t a;
      a.mask   = dif.out_exec_mask;
      a.pc     = dif.out_pc;
      a.opcode = dif.out_opcode;
      a.rd     = dif.out_rd;
      a.rs1    = dif.out_rs1;
      a.rs2    = dif.out_rs2;
      a.imm    = dif.out_imm;
      a.wr     = dif.out_writes_rd;
      a.r1     = dif.out_reads_rs1;
      a.r2     = dif.out_reads_rs2;
      a.cf     = dif.out_is_cf;
      a.ill    = dif.out_illegal;
      return a;
   endfunction

   task automatic check(input string name, input logic [159:0] got, input logic [159:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", name, got, exp);
      end
   endtask

   // Scoreboard side: expectations enter on accept and leave on issue.
   always @(negedge clk) begin
      if (!reset) begin
         if (dif.out_valid && !dif.out_busy) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_issue: got opcode %h with nothing pending", dif.out_opcode);
            end else begin
               check("issue_packet", 160'(get_act()), 160'(exp_q.pop_front()));
            end
         end
         if (dif.in_valid && !dif.in_busy) exp_q.push_back(cur_exp);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] insn, input exp_t e);
      int n;
      n                = 0;
      cur_exp          = e;
      dif.in_valid     = 1'b1;
      dif.in_insn      = insn;
      dif.in_exec_mask = e.mask;
      dif.in_pc        = e.pc;
      @(negedge clk);
      while (dif.in_busy && n < 40) begin
         n++;
         @(negedge clk);
      end
      if (dif.in_busy) begin
         n_checks++;
         n_fail++;
         $display("FAIL accept_timeout: in_busy still 1 after %0d cycles, required 0", n);
      end
      tick();
      dif.in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 40) begin
         n++;
         @(negedge clk);
      end
      #1;
      if (exp_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain_timeout: %0d packets pending, required 0", exp_q.size());
      end
   endtask

   task automatic wb(input logic [3:0] r);
      tick();
      dif.wb_valid = 1'b1;
      dif.wb_reg   = r;
      tick();
      dif.wb_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e, e2;
      n_checks = 0;
      n_fail   = 0;
      cur_exp  = '0;

      tbl[0]  = '{32'h00000203, mk(8'h03, 4'h2, 4'h0, 4'h0, 32'h00000000, 5'b11100)};
      tbl[1]  = '{32'hFFFE0102, mk(8'h02, 4'h1, 4'h0, 4'hE, 32'hFFFFFFFE, 5'b10000)};
      tbl[2]  = '{32'h80016106, mk(8'h06, 4'h1, 4'h6, 4'h1, 32'hFFFFF800, 5'b11000)};
      tbl[3]  = '{32'h00F23407, mk(8'h07, 4'h4, 4'h3, 4'h2, 32'h0000000F, 5'b01100)};
      tbl[4]  = '{32'h00400011, mk(8'h11, 4'h0, 4'h0, 4'h0, 32'h00000040, 5'b00010)};
      tbl[5]  = '{32'h0000213F, mk(8'h3F, 4'h1, 4'h2, 4'h0, 32'h00000000, 5'b00001)};
      tbl[6]  = '{32'h00000001, mk(8'h01, 4'h0, 4'h0, 4'h0, 32'h00000000, 5'b00010)};
      tbl[7]  = '{32'h00054505, mk(8'h05, 4'h5, 4'h4, 4'h5, 32'h00000000, 5'b01100)};
      tbl[8]  = '{32'h00098A04, mk(8'h04, 4'hA, 4'h8, 4'h9, 32'h00000000, 5'b11100)};
      tbl[9]  = '{32'h80000010, mk(8'h10, 4'h0, 4'h0, 4'h0, 32'hFFFF8000, 5'b00010)};
      tbl[10] = '{32'h00003017, mk(8'h17, 4'h0, 4'h3, 4'h0, 32'h00000000, 5'b01010)};
      tbl[11] = '{32'hFFFFFF00, mk(8'h00, 4'hF, 4'hF, 4'hF, 32'h00000000, 5'b00000)};
      tbl[12] = '{32'hFFFF0016, mk(8'h16, 4'h0, 4'h0, 4'hF, 32'hFFFFFFFF, 5'b00010)};
      tbl[13] = '{32'h00000018, mk(8'h18, 4'h0, 4'h0, 4'h0, 32'h00000000, 5'b00001)};

      dif.in_valid     = 1'b0;
      dif.in_exec_mask = '0;
      dif.in_pc        = '0;
      dif.in_insn      = '0;
      dif.out_busy     = 1'b0;
      dif.wb_valid     = 1'b0;
      dif.wb_reg       = '0;
      reset            = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("reset_state", 160'({dif.out_valid, dif.in_busy, get_act()}), 160'(0));

      // Decode table: each packet must issue one cycle after accept.
      for (int i = 0; i < 14; i++) begin
         tick();
         e = randctx(tbl[i].exp);
         send(tbl[i].insn, e);
         @(negedge clk);
         check($sformatf("issue_latency_%0d", i), 160'(dif.out_valid), 160'(1));
         drain();
         if (e.wr) wb(e.rd);
      end

      // RAW hazard on r2, released only by writeback with no bypass.
      tick();
      send(32'h00000203, randctx(mk(8'h03, 4'h2, 4'h0, 4'h0, 32'h0, 5'b11100)));
      drain();
      tick();
      send(32'h00002303, randctx(mk(8'h03, 4'h3, 4'h2, 4'h0, 32'h0, 5'b11100)));
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("raw_stall", 160'({dif.out_valid, dif.in_busy}), 160'(2'b01));
      end
      tick();
      dif.wb_valid = 1'b1;
      dif.wb_reg   = 4'h2;
      @(negedge clk);
      check("no_wb_bypass", 160'(dif.out_valid), 160'(0));
      tick();
      dif.wb_valid = 1'b0;
      @(negedge clk);
      check("wb_release", 160'(dif.out_valid), 160'(1));
      drain();
      wb(4'h3);

      // Issue setting r5 and a writeback of r5 in the same cycle: set must win.
      tick();
      dif.out_busy = 1'b1;
      send(32'h00000503, randctx(mk(8'h03, 4'h5, 4'h0, 4'h0, 32'h0, 5'b11100)));
      dif.out_busy = 1'b0;
      dif.wb_valid = 1'b1;
      dif.wb_reg   = 4'h5;
      tick();
      dif.wb_valid = 1'b0;
      send(32'h00005603, randctx(mk(8'h03, 4'h6, 4'h5, 4'h0, 32'h0, 5'b11100)));
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         check("set_wins_stall", 160'(dif.out_valid), 160'(0));
      end
      wb(4'h5);
      @(negedge clk);
      check("set_wins_release", 160'(dif.out_valid), 160'(1));
      drain();
      wb(4'h6);

      // Backpressure: outputs frozen, then fire and accept in the same cycle.
      tick();
      dif.out_busy = 1'b1;
      e = mk(8'h02, 4'h1, 4'h0, 4'hE, 32'hFFFFFFFE, 5'b10000);
      e.mask = 64'hDEAD_BEEF_0123_4567;
      e.pc   = 32'h0000_1000;
      send(32'hFFFE0102, e);
      e2 = mk(8'h03, 4'h4, 4'h0, 4'h0, 32'h0, 5'b11100);
      e2.mask = 64'h0000_0000_FFFF_0000;
      e2.pc   = 32'h0000_1004;
      cur_exp          = e2;
      dif.in_valid     = 1'b1;
      dif.in_insn      = 32'h00000403;
      dif.in_exec_mask = e2.mask;
      dif.in_pc        = e2.pc;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("bp_stable", 160'({dif.out_valid, dif.in_busy, get_act()}), 160'({2'b11, e}));
      end
      tick();
      dif.out_busy = 1'b0;
      @(negedge clk);
      check("fire_and_accept", 160'({dif.out_valid, dif.in_busy}), 160'(2'b10));
      tick();
      dif.in_valid = 1'b0;
      @(negedge clk);
      check("back_to_back", 160'({dif.out_valid, get_act()}), 160'({1'b1, e2}));
      drain();
      wb(4'h1);
      wb(4'h4);

      // Reset with r7 pending and a held packet stalled by out_busy.
      tick();
      send(32'h00000703, randctx(mk(8'h03, 4'h7, 4'h0, 4'h0, 32'h0, 5'b11100)));
      drain();
      tick();
      dif.out_busy = 1'b1;
      send(32'h00000803, randctx(mk(8'h03, 4'h8, 4'h0, 4'h0, 32'h0, 5'b11100)));
      reset = 1'b1;
      tick();
      reset        = 1'b0;
      dif.out_busy = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check("reset_flush", 160'({dif.out_valid, dif.in_busy, get_act()}), 160'(0));
      tick();
      send(32'h00007903, randctx(mk(8'h03, 4'h9, 4'h7, 4'h0, 32'h0, 5'b11100)));
      @(negedge clk);
      check("reset_clears_sb", 160'(dif.out_valid), 160'(1));
      drain();
      wb(4'h9);

      tick();
      check("queue_empty", 160'(exp_q.size()), 160'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
